// File: rtl/any1_ifetch_line.sv
`default_nettype none
// ============================================================================
//  Module      : any1_ifetch_line
//  Description : Line-oriented instruction fetch for the ANY-1 front end.
//                Fetches 512-bit lines as four 128-bit bus beats and hands
//                one instruction-align record per instruction address to the
//                aligner, following redirects, BTB predictions and bus errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module any1_ifetch_line #(
    parameter int              AWID  = 32,
    parameter logic [AWID-1:0] RSTIP = 32'hFFFD0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redirect_i,
    input  logic [AWID-1:0]   redirect_ip_i,
    input  logic              btb_hit_i,
    input  logic [AWID-1:0]   btb_tgt_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [15:0]       sel_o,
    output logic [AWID-1:0]   adr_o,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic [127:0]      dat_i,
    output logic              ia_valid_o,
    input  logic              ia_ready_i,
    output logic [5:0]        stream_o,
    output logic [5:0]        rid_o,
    output logic [AWID-1:0]   ip_o,
    output logic [AWID-1:0]   pip_o,
    output logic              predict_taken_o,
    output logic [511:0]      cacheline_o,
    output logic [7:0]        cause_o
);

    localparam int         c_TAGW     = AWID - 6;
    localparam logic [7:0] c_FLT_IADR = 8'h36;

    localparam logic [1:0] c_ST_FETCH   = 2'd0;
    localparam logic [1:0] c_ST_DELIVER = 2'd1;
    localparam logic [1:0] c_ST_FAULT   = 2'd2;

    // architectural state
    logic [1:0]        r_state;
    logic [AWID-1:0]   r_ip;
    logic [5:0]        r_stream;
    logic [5:0]        r_rid;
    logic [1:0]        r_beat;
    logic              r_line_v;
    logic [c_TAGW-1:0] r_line_tag;
    logic [511:0]      r_line;

    // registered outputs
    logic              r_cyc;
    logic [AWID-1:0]   r_adr;
    logic              r_valid;
    logic [7:0]        r_cause;

    // next-state values
    logic [1:0]        w_state_nxt;
    logic [AWID-1:0]   w_ip_nxt;
    logic [5:0]        w_stream_nxt;
    logic [5:0]        w_rid_nxt;
    logic [1:0]        w_beat_nxt;
    logic              w_line_v_nxt;
    logic [c_TAGW-1:0] w_line_tag_nxt;
    logic              w_store;

    // next output values
    logic              w_cyc_nxt;
    logic [AWID-1:0]   w_adr_nxt;
    logic              w_valid_nxt;
    logic [7:0]        w_cause_nxt;

    logic [AWID-1:0]   w_pip;
    logic              w_ack;
    logic              w_err;
    logic              w_hs;

    // Bus responses only count while our cycle is actually on the bus;
    // an error overrides a simultaneous acknowledge.
    assign w_err = r_cyc & err_i;
    assign w_ack = r_cyc & ack_i & ~err_i;
    assign w_hs  = r_valid & ia_ready_i;

    // Next-ip prediction is combinational from the current ip and BTB lookup.
    assign w_pip = btb_hit_i ? btb_tgt_i : r_ip + AWID'(8);

    // State register: all sequential state plus registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_FETCH;
            r_ip       <= RSTIP;
            r_stream   <= 6'd0;
            r_rid      <= 6'd0;
            r_beat     <= 2'd0;
            r_line_v   <= 1'b0;
            r_line_tag <= '0;
            r_line     <= '0;
            r_cyc      <= 1'b0;
            r_adr      <= '0;
            r_valid    <= 1'b0;
            r_cause    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_ip       <= w_ip_nxt;
            r_stream   <= w_stream_nxt;
            r_rid      <= w_rid_nxt;
            r_beat     <= w_beat_nxt;
            r_line_v   <= w_line_v_nxt;
            r_line_tag <= w_line_tag_nxt;
            r_cyc      <= w_cyc_nxt;
            r_adr      <= w_adr_nxt;
            r_valid    <= w_valid_nxt;
            r_cause    <= w_cause_nxt;
            if (w_store) begin
                r_line[{r_beat, 7'd0} +: 128] <= dat_i;
            end
        end
    end

    // Next-state logic: redirect has priority and voids any handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_ip_nxt       = r_ip;
        w_stream_nxt   = r_stream;
        w_rid_nxt      = r_rid;
        w_beat_nxt     = r_beat;
        w_line_v_nxt   = r_line_v;
        w_line_tag_nxt = r_line_tag;
        w_store        = 1'b0;

        if (redirect_i) begin
            w_ip_nxt     = redirect_ip_i;
            w_stream_nxt = r_stream + 6'd1;
            if (r_state == c_ST_DELIVER) begin
                // Target inside the buffered line: keep delivering from it.
                if (!(r_line_v && (redirect_ip_i[AWID-1:6] == r_line_tag))) begin
                    w_state_nxt = c_ST_FETCH;
                    w_beat_nxt  = 2'd0;
                end
            end else begin
                // Abandon any partial fetch; the ack of this cycle is dropped.
                w_state_nxt  = c_ST_FETCH;
                w_beat_nxt   = 2'd0;
                w_line_v_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (w_err) begin
                        w_state_nxt  = c_ST_FAULT;
                        w_beat_nxt   = 2'd0;
                        w_line_v_nxt = 1'b0;
                    end else if (w_ack) begin
                        w_store    = 1'b1;
                        w_beat_nxt = r_beat + 2'd1;
                        if (r_beat == 2'd3) begin
                            w_state_nxt    = c_ST_DELIVER;
                            w_line_tag_nxt = r_ip[AWID-1:6];
                            w_line_v_nxt   = 1'b1;
                        end
                    end
                end
                c_ST_DELIVER: begin
                    if (w_hs) begin
                        w_rid_nxt = r_rid + 6'd1;
                        w_ip_nxt  = w_pip;
                        if (w_pip[AWID-1:6] != r_line_tag) begin
                            w_state_nxt = c_ST_FETCH;
                            w_beat_nxt  = 2'd0;
                        end
                    end
                end
                c_ST_FAULT: begin
                    // A faulting line is never reused; always refetch.
                    if (w_hs) begin
                        w_rid_nxt   = r_rid + 6'd1;
                        w_ip_nxt    = w_pip;
                        w_state_nxt = c_ST_FETCH;
                        w_beat_nxt  = 2'd0;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_FETCH;
                    w_beat_nxt  = 2'd0;
                end
            endcase
        end
    end

    // Output logic: values for the output registers, derived from next state.
    always_comb begin
        // A redirect that lands while the bus is busy forces one idle cycle.
        w_cyc_nxt   = (w_state_nxt == c_ST_FETCH) && !(redirect_i && r_cyc);
        w_adr_nxt   = {w_ip_nxt[AWID-1:6], w_beat_nxt, 4'h0};
        w_valid_nxt = (w_state_nxt != c_ST_FETCH);
        w_cause_nxt = (w_state_nxt == c_ST_FAULT) ? c_FLT_IADR : 8'h00;
    end

    assign cyc_o           = r_cyc;
    assign stb_o           = r_cyc;
    assign sel_o           = 16'hFFFF;
    assign adr_o           = r_adr;
    assign ia_valid_o      = r_valid;
    assign cause_o         = r_cause;
    assign stream_o        = r_stream;
    assign rid_o           = r_rid;
    assign ip_o            = r_ip;
    assign pip_o           = w_pip;
    assign predict_taken_o = btb_hit_i;
    assign cacheline_o     = r_line;

endmodule
`default_nettype wire

// File: tb/tb_any1_ifetch_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_any1_ifetch_line
//  Description : Scoreboard bench for any1_ifetch_line. Stimulus pushes the
//                expected records and line fetches; monitors compare them
//                against what the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_any1_ifetch_line;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         redirect_i;
    logic [31:0]  redirect_ip_i;
    logic         btb_hit_i;
    logic [31:0]  btb_tgt_i;
    logic         cyc_o;
    logic         stb_o;
    logic [15:0]  sel_o;
    logic [31:0]  adr_o;
    logic         ack_i = 1'b0;
    logic         err_i = 1'b0;
    logic [127:0] dat_i = '0;
    logic         ia_valid_o;
    logic         ia_ready_i;
    logic [5:0]   stream_o;
    logic [5:0]   rid_o;
    logic [31:0]  ip_o;
    logic [31:0]  pip_o;
    logic         predict_taken_o;
    logic [511:0] cacheline_o;
    logic [7:0]   cause_o;

    any1_ifetch_line #(.AWID(32), .RSTIP(32'hFFFD0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .redirect_i(redirect_i), .redirect_ip_i(redirect_ip_i),
        .btb_hit_i(btb_hit_i), .btb_tgt_i(btb_tgt_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o), .adr_o(adr_o),
        .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
        .ia_valid_o(ia_valid_o), .ia_ready_i(ia_ready_i),
        .stream_o(stream_o), .rid_o(rid_o), .ip_o(ip_o), .pip_o(pip_o),
        .predict_taken_o(predict_taken_o), .cacheline_o(cacheline_o),
        .cause_o(cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] ip;
        logic [5:0]  rid;
        logic [5:0]  stream;
        logic [7:0]  cause;
    } rec_t;

    rec_t        exp_rec[$];
    logic [31:0] exp_fetch[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;

    // error injection for the slave
    logic [31:0] err_adr  = '0;
    logic        err_both = 1'b0;
    logic        err_arm  = 1'b0;

    function automatic logic [127:0] beat_data(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A5A5A, a + 32'h01234567};
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] ip);
        logic [511:0] l;
        logic [31:0]  b;
        b = {ip[31:6], 6'h0};
        for (int i = 0; i < 4; i++) begin
            l[i*128 +: 128] = beat_data(b + 32'(i * 16));
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_rec(input logic [31:0] ip, input logic [5:0] rid,
                            input logic [5:0] stream, input logic [7:0] cause);
        rec_t r;
        r.ip = ip; r.rid = rid; r.stream = stream; r.cause = cause;
        exp_rec.push_back(r);
    endtask

    task automatic wait_acc(input int n);
        int t;
        t = 0;
        while (n_acc < n && t < 2000) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        if (n_acc < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_acc timeout: got %0d expected %0d", n_acc, n);
        end
    endtask

    task automatic wait_adr(input logic [31:0] a);
        int t;
        t = 0;
        while (!(cyc_o && adr_o == a) && t < 200) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        if (!(cyc_o && adr_o == a)) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_adr timeout: got %0h expected %0h", adr_o, a);
        end
    endtask

    // Zero-wait bus slave with optional one-shot error injection.
    always @(posedge clk_i) begin
        #1;
        ack_i = 1'b0;
        err_i = 1'b0;
        if (cyc_o && stb_o) begin
            dat_i = beat_data(adr_o);
            if (err_arm && adr_o == err_adr) begin
                err_i   = 1'b1;
                ack_i   = err_both;
                err_arm = 1'b0;
            end else begin
                ack_i = 1'b1;
            end
        end
    end

    // Bus monitor: each new bus cycle must match the next expected line and
    // step through the beats in order.
    logic        cyc_q = 1'b0;
    logic [31:0] base  = '0;
    int          k     = 0;
    always @(negedge clk_i) begin
        if (cyc_o && !cyc_q) begin
            if (exp_fetch.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_fetch: got %0h expected none", adr_o);
            end else begin
                base = exp_fetch.pop_front();
                k    = 0;
            end
        end
        if (cyc_o) begin
            chk("bus_adr", adr_o, base + 32'(k * 16));
            chk("bus_stb", stb_o, 1'b1);
            if (ack_i && !err_i && !redirect_i && !rst_i) k++;
        end
        cyc_q = cyc_o;
    end

    // Record monitor: compare presented records against the scoreboard.
    always @(negedge clk_i) begin
        rec_t e;
        if (!rst_i && !redirect_i && ia_valid_o) begin
            if (exp_rec.size() == 0) begin
                if (ia_ready_i) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_record: got ip %0h rid %0d expected none", ip_o, rid_o);
                end
            end else begin
                e = exp_rec[0];
                chk("rec_ip", ip_o, e.ip);
                chk("rec_rid", rid_o, e.rid);
                chk("rec_stream", stream_o, e.stream);
                chk("rec_cause", cause_o, e.cause);
                if (e.cause == 8'h00) chk("rec_line", cacheline_o, line_of(e.ip));
                if (ia_ready_i) void'(exp_rec.pop_front());
            end
            if (ia_ready_i) n_acc++;
        end
    end

    initial begin
        rst_i = 1'b1; redirect_i = 1'b0; redirect_ip_i = '0;
        btb_hit_i = 1'b0; btb_tgt_i = '0; ia_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_adr", adr_o, 32'h0);
        chk("rst_valid", ia_valid_o, 1'b0);
        chk("rst_cause", cause_o, 8'h00);
        chk("rst_line", cacheline_o, 512'h0);
        chk("rst_ip", ip_o, 32'hFFFD0000);
        chk("rst_sel", sel_o, 16'hFFFF);

        // Reset fetch and sequential delivery across a line boundary.
        exp_fetch.push_back(32'hFFFD0000);
        for (int i = 0; i < 8; i++) push_rec(32'hFFFD0000 + 32'(8 * i), 6'(i), 6'd0, 8'h00);
        exp_fetch.push_back(32'hFFFD0040);
        push_rec(32'hFFFD0040, 6'd8, 6'd0, 8'h00);
        push_rec(32'hFFFD0048, 6'd9, 6'd0, 8'h00);
        ia_ready_i = 1'b1;
        rst_i = 1'b0;
        wait_acc(9);
        ia_ready_i = 1'b0;

        // Backpressure: record rid 9 held for 5 cycles, then accepted.
        repeat (5) @(posedge clk_i);
        #1;
        ia_ready_i = 1'b1;
        wait_acc(10);
        ia_ready_i = 1'b0;

        // Redirect that hits the buffered line.
        push_rec(32'hFFFD0070, 6'd10, 6'd1, 8'h00);
        redirect_ip_i = 32'hFFFD0070;
        redirect_i = 1'b1;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        ia_ready_i = 1'b1;
        wait_acc(11);
        ia_ready_i = 1'b0;

        // BTB-predicted taken branch to another line.
        chk("pip_seq", pip_o, 32'hFFFD0080);
        chk("taken_seq", predict_taken_o, 1'b0);
        btb_hit_i = 1'b1;
        btb_tgt_i = 32'hFFFE0000;
        #1;
        chk("pip_btb", pip_o, 32'hFFFE0000);
        chk("taken_btb", predict_taken_o, 1'b1);
        push_rec(32'hFFFD0078, 6'd11, 6'd1, 8'h00);
        exp_fetch.push_back(32'hFFFE0000);
        push_rec(32'hFFFE0000, 6'd12, 6'd1, 8'h00);
        ia_ready_i = 1'b1;
        wait_acc(12);
        btb_hit_i = 1'b0;
        wait_acc(13);
        ia_ready_i = 1'b0;

        // Redirect during beat 2 of a fetch.
        exp_fetch.push_back(32'h00002000);
        exp_fetch.push_back(32'h00001000);
        push_rec(32'h00001000, 6'd13, 6'd3, 8'h00);
        redirect_ip_i = 32'h00002000;
        redirect_i = 1'b1;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        wait_adr(32'h00002020);
        redirect_ip_i = 32'h00001000;
        redirect_i = 1'b1;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        chk("redir_cyc_drop", cyc_o, 1'b0);
        ia_ready_i = 1'b1;
        wait_acc(14);
        ia_ready_i = 1'b0;

        // Bus error on beat 1, then refetch of the pip line.
        err_adr = 32'h00003010; err_both = 1'b0; err_arm = 1'b1;
        exp_fetch.push_back(32'h00003000);
        push_rec(32'h00003000, 6'd14, 6'd4, 8'h36);
        exp_fetch.push_back(32'h00003000);
        push_rec(32'h00003008, 6'd15, 6'd4, 8'h00);
        redirect_ip_i = 32'h00003000;
        redirect_i = 1'b1;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        ia_ready_i = 1'b1;
        wait_acc(16);
        ia_ready_i = 1'b0;

        // ack and err together on beat 0 behave as an error.
        err_adr = 32'h00004000; err_both = 1'b1; err_arm = 1'b1;
        exp_fetch.push_back(32'h00004000);
        push_rec(32'h00004000, 6'd16, 6'd5, 8'h36);
        exp_fetch.push_back(32'h00004000);
        push_rec(32'h00004008, 6'd17, 6'd5, 8'h00);
        redirect_ip_i = 32'h00004000;
        redirect_i = 1'b1;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        ia_ready_i = 1'b1;
        wait_acc(18);
        ia_ready_i = 1'b0;

        // Reset asserted in the middle of a fetch.
        exp_fetch.push_back(32'h00005000);
        redirect_ip_i = 32'h00005000;
        redirect_i = 1'b1;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        wait_adr(32'h00005010);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("mid_rst_cyc", cyc_o, 1'b0);
        chk("mid_rst_stb", stb_o, 1'b0);
        chk("mid_rst_valid", ia_valid_o, 1'b0);
        chk("mid_rst_ip", ip_o, 32'hFFFD0000);
        chk("mid_rst_rid", rid_o, 6'd0);
        chk("mid_rst_stream", stream_o, 6'd0);
        chk("mid_rst_adr", adr_o, 32'h0);
        exp_fetch.push_back(32'hFFFD0000);
        push_rec(32'hFFFD0000, 6'd0, 6'd0, 8'h00);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ia_ready_i = 1'b1;
        wait_acc(19);
        ia_ready_i = 1'b0;

        repeat (4) @(posedge clk_i);
        #1;
        chk("rec_queue_empty", 32'(exp_rec.size()), 32'd0);
        chk("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
